mux_share_arbiter: RTL

Round-robin arbiter that shares one N:1 multiplexer datapath between N requesters and drives its select. Each requester offers a W-bit word with a valid/ready handshake. The arbiter picks one winner per transfer, steers the mux and captures the selected word into a one-entry output register. The output side is a single valid/ready stream feeding the downstream consumer.

---
 rtl/mux_share_pkg.sv | 22 ++
 rtl/rr_pick.sv | 38 +++
 rtl/mux_share_arbiter.sv | 67 ++++++
 3 files changed

// File: rtl/mux_share_pkg.sv
// rtl/mux_share_pkg.sv - shared constants and helpers for mux-sharing arbiters
package mux_share_pkg;

    localparam logic ARB_FIXED = 1'b0;
    localparam logic ARB_RR    = 1'b1;

    // Largest requester count a sharing block may use; helpers are sized for it.
    localparam int MAX_N = 16;
    localparam int IDX_W = 4;

    function automatic logic [IDX_W-1:0] onehot_to_idx(input logic [MAX_N-1:0] oh);
        logic [IDX_W-1:0] r_idx;
        r_idx = '0;
        for (int i = 0; i < MAX_N; i++) begin
            if (oh[i]) begin
                r_idx = r_idx | IDX_W'(i);
            end
        end
        return r_idx;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// rtl/rr_pick.sv - combinational rotating-priority picker
module rr_pick
    import mux_share_pkg::*;
#(
    parameter int N     = 4,
    parameter int SEL_W = $clog2(N)
) (
    input  logic [N-1:0]     req,
    input  logic [SEL_W-1:0] ptr,
    input  logic             rr_en,
    output logic             any,
    output logic [SEL_W-1:0] idx
);

    logic [N-1:0]     w_hi;
    logic [N-1:0]     w_masked;
    logic [N-1:0]     w_src;
    logic [N-1:0]     w_oh;
    logic [MAX_N-1:0] w_oh_wide;

    // Requests at or above ptr win first; if none, the lowest request wraps around.
    always_comb begin
        w_hi = '0;
        for (int i = 0; i < N; i++) begin
            if (SEL_W'(i) >= ptr) begin
                w_hi[i] = 1'b1;
            end
        end
        w_masked  = (rr_en == ARB_RR) ? (req & w_hi) : '0;
        w_src     = (|w_masked) ? w_masked : req;
        w_oh      = w_src & (~w_src + N'(1));
        w_oh_wide = '0;
        w_oh_wide[N-1:0] = w_oh;
        idx = SEL_W'(onehot_to_idx(w_oh_wide));
        any = |req;
    end

endmodule

// File: rtl/mux_share_arbiter.sv
// rtl/mux_share_arbiter.sv - round-robin arbiter steering a shared N:1 data mux
module mux_share_arbiter
    import mux_share_pkg::*;
#(
    parameter int N     = 4,
    parameter int W     = 8,
    parameter int SEL_W = $clog2(N)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N-1:0]     in_valid,
    input  logic [N*W-1:0]   in_data,
    output logic [N-1:0]     in_ready,
    input  logic             rr_en,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [W-1:0]     out_data,
    output logic [SEL_W-1:0] out_sel
);

    logic [SEL_W-1:0] r_ptr;
    logic             r_out_valid;
    logic [W-1:0]     r_out_data;
    logic [SEL_W-1:0] r_out_sel;

    logic             w_any;
    logic [SEL_W-1:0] w_idx;
    logic             w_load;
    logic [W-1:0]     w_data;

    rr_pick #(
        .N     (N),
        .SEL_W (SEL_W)
    ) u_pick (
        .req   (in_valid),
        .ptr   (r_ptr),
        .rr_en (rr_en),
        .any   (w_any),
        .idx   (w_idx)
    );

    // Loading while FULL is allowed only when the consumer drains in the same edge.
    assign w_load   = !rst && w_any && (!r_out_valid || out_ready);
    assign in_ready = w_load ? (N'(1) << w_idx) : '0;
    assign w_data   = in_data[int'(w_idx)*W +: W];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_ptr       <= '0;
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_sel   <= '0;
        end else if (w_load) begin
            r_ptr       <= (w_idx == SEL_W'(N-1)) ? '0 : w_idx + 1'b1;
            r_out_valid <= 1'b1;
            r_out_data  <= w_data;
            r_out_sel   <= w_idx;
        end else if (out_ready) begin
            r_out_valid <= 1'b0;
        end
    end

    assign out_valid = r_out_valid;
    assign out_data  = r_out_data;
    assign out_sel   = r_out_sel;

endmodule
